ce_tile_scheduler: RTL and testbench

- Sequences TILE commands into compute_engine_modular.
- Buffers up to CMD_DEPTH commands and issues one tile at a time with a 1-cycle enable pulse. Holds tile parameters stable while the tile runs.
- Counts FP16 results, waits for tile_done plus a drain window, then emits one status record per tile: ok, count mismatch, timeout or bad dims.
- Sits between the command decoder and the compute engine; gates issue on result-FIFO almost-full.

---
 rtl/ce_tile_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ce_tile_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_tile_scheduler.sv
// Tile scheduler for compute_engine_modular: queues TILE commands, issues one tile at a
// time, counts FP16 results through a post-done drain window and reports one status per tile.
module ce_tile_scheduler #(
    parameter int ADDR_W    = 11,
    parameter int CMD_DEPTH = 4,
    parameter int ID_W      = 8,
    parameter int TMO_W     = 20,
    parameter int DRAIN_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ID_W-1:0]   i_cmd_id,
    input  logic [ADDR_W-1:0] i_cmd_left_addr,
    input  logic [ADDR_W-1:0] i_cmd_right_addr,
    input  logic [7:0]        i_cmd_dim_b,
    input  logic [7:0]        i_cmd_dim_c,
    input  logic [7:0]        i_cmd_dim_v,
    input  logic [TMO_W-1:0]  i_timeout_cycles,
    output logic              o_tile_en,
    output logic [ADDR_W-1:0] o_left_addr,
    output logic [ADDR_W-1:0] o_right_addr,
    output logic [7:0]        o_dim_b,
    output logic [7:0]        o_dim_c,
    output logic [7:0]        o_dim_v,
    input  logic              i_tile_done,
    input  logic              i_result_valid,
    input  logic              i_result_afull,
    output logic              o_sts_valid,
    input  logic              i_sts_ready,
    output logic [ID_W-1:0]   o_sts_id,
    output logic [1:0]        o_sts_code,
    output logic [15:0]       o_sts_count,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;
    localparam logic [1:0] CODE_BADDIM  = 2'd3;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] left;
        logic [ADDR_W-1:0] right;
        logic [7:0]        b;
        logic [7:0]        c;
        logic [7:0]        v;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    cmd_t             mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   occ_q;
    cmd_t             cmd_in, head, hold_q;
    logic             full, empty, push, pop, head_bad;

    logic [15:0]      cnt_q, cnt_nxt, prod;
    logic [TMO_W-1:0] tmr_q, lim_q;
    logic [DRN_W-1:0] drn_q;
    logic [1:0]       code_q;
    logic             cnt_inc, timeout_hit, drain_end;

    // ---------------- command queue ----------------
    assign cmd_in = '{id: i_cmd_id, left: i_cmd_left_addr, right: i_cmd_right_addr,
                      b: i_cmd_dim_b, c: i_cmd_dim_c, v: i_cmd_dim_v};
    assign head     = mem_q[rd_ptr_q];
    assign full     = (occ_q == (PTR_W+1)'(CMD_DEPTH));
    assign empty    = (occ_q == '0);
    assign head_bad = (head.b == 8'd0) || (head.c == 8'd0) || (head.v == 8'd0);

    // Readiness comes from current occupancy only, so a same-cycle pop never frees a full slot.
    assign o_cmd_ready = !full && !i_reset;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state_q == S_IDLE) && !empty && (head_bad || !i_result_afull);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q <= occ_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // ---------------- tile FSM ----------------
    assign prod        = {8'd0, hold_q.b} * {8'd0, hold_q.c};
    assign cnt_inc     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && i_result_valid;
    assign cnt_nxt     = (cnt_inc && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    assign timeout_hit = (lim_q != '0) && ((tmr_q + TMO_W'(1)) == lim_q);
    assign drain_end   = (drn_q == DRN_W'(DRAIN_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (pop) state_d = head_bad ? S_REPORT : S_ISSUE;
            S_ISSUE:  state_d = S_RUN;
            S_RUN: begin
                if (i_tile_done)      state_d = S_DRAIN;
                else if (timeout_hit) state_d = S_REPORT;
            end
            S_DRAIN:  if (drain_end) state_d = S_REPORT;
            S_REPORT: if (i_sts_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_tile_en   = 1'b0;
        o_sts_valid = 1'b0;
        o_busy      = !empty;
        unique case (state_q)
            S_IDLE:   ;
            S_ISSUE:  begin o_tile_en = 1'b1;   o_busy = 1'b1; end
            S_REPORT: begin o_sts_valid = 1'b1; o_busy = 1'b1; end
            default:  o_busy = 1'b1;
        endcase
    end

    // ---------------- held parameters, counters, status ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_q <= '0;
            cnt_q  <= '0;
            tmr_q  <= '0;
            lim_q  <= '0;
            drn_q  <= '0;
            code_q <= CODE_OK;
        end else begin
            if (pop) begin
                hold_q <= head;
                cnt_q  <= '0;
                if (head_bad) code_q <= CODE_BADDIM;
            end
            unique case (state_q)
                S_ISSUE: begin
                    cnt_q <= '0;
                    tmr_q <= '0;
                    drn_q <= '0;
                    lim_q <= i_timeout_cycles;
                end
                S_RUN: begin
                    cnt_q <= cnt_nxt;
                    tmr_q <= tmr_q + TMO_W'(1);
                    if (!i_tile_done && timeout_hit) code_q <= CODE_TIMEOUT;
                end
                S_DRAIN: begin
                    cnt_q <= cnt_nxt;
                    drn_q <= drn_q + DRN_W'(1);
                    // Judge against the count including a result landing in the last drain cycle.
                    if (drain_end) code_q <= (cnt_nxt == prod) ? CODE_OK : CODE_MISMATCH;
                end
                default: ;
            endcase
        end
    end

    assign o_left_addr  = hold_q.left;
    assign o_right_addr = hold_q.right;
    assign o_dim_b      = hold_q.b;
    assign o_dim_c      = hold_q.c;
    assign o_dim_v      = hold_q.v;
    assign o_sts_id     = hold_q.id;
    assign o_sts_code   = code_q;
    assign o_sts_count  = cnt_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_ce_tile_scheduler.sv
// Directed bench for ce_tile_scheduler: CE behaviour is driven inline, expected status
// records are queued at command time and checked as the DUT reports them.
module tb_ce_tile_scheduler;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_id = '0;
    logic [10:0] i_cmd_left_addr = '0;
    logic [10:0] i_cmd_right_addr = '0;
    logic [7:0]  i_cmd_dim_b = '0;
    logic [7:0]  i_cmd_dim_c = '0;
    logic [7:0]  i_cmd_dim_v = '0;
    logic [19:0] i_timeout_cycles = '0;
    logic        o_tile_en;
    logic [10:0] o_left_addr, o_right_addr;
    logic [7:0]  o_dim_b, o_dim_c, o_dim_v;
    logic        i_tile_done = 1'b0;
    logic        i_result_valid = 1'b0;
    logic        i_result_afull = 1'b0;
    logic        o_sts_valid;
    logic        i_sts_ready = 1'b0;
    logic [7:0]  o_sts_id;
    logic [1:0]  o_sts_code;
    logic [15:0] o_sts_count;
    logic        o_busy;
    logic [2:0]  o_state;

    ce_tile_scheduler dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_id(i_cmd_id), .i_cmd_left_addr(i_cmd_left_addr),
        .i_cmd_right_addr(i_cmd_right_addr),
        .i_cmd_dim_b(i_cmd_dim_b), .i_cmd_dim_c(i_cmd_dim_c), .i_cmd_dim_v(i_cmd_dim_v),
        .i_timeout_cycles(i_timeout_cycles),
        .o_tile_en(o_tile_en), .o_left_addr(o_left_addr), .o_right_addr(o_right_addr),
        .o_dim_b(o_dim_b), .o_dim_c(o_dim_c), .o_dim_v(o_dim_v),
        .i_tile_done(i_tile_done), .i_result_valid(i_result_valid),
        .i_result_afull(i_result_afull),
        .o_sts_valid(o_sts_valid), .i_sts_ready(i_sts_ready),
        .o_sts_id(o_sts_id), .o_sts_code(o_sts_code), .o_sts_count(o_sts_count),
        .o_busy(o_busy), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  id;
        logic [1:0]  code;
        logic [15:0] cnt;
    } sts_t;

    sts_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   en_cnt = 0;
    int   e0;

    always @(negedge i_clk) if (o_tile_en) en_cnt <= en_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sb_push(input logic [7:0] id, input logic [1:0] code, input logic [15:0] cnt);
        sb.push_back('{id, code, cnt});
    endtask

    task automatic push_cmd(input logic [7:0] id, input logic [10:0] la, input logic [10:0] ra,
                            input logic [7:0] b, input logic [7:0] c, input logic [7:0] v);
        bit ok = 1'b0;
        i_cmd_id = id; i_cmd_left_addr = la; i_cmd_right_addr = ra;
        i_cmd_dim_b = b; i_cmd_dim_c = c; i_cmd_dim_v = v;
        i_cmd_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (o_cmd_ready) begin tick(); ok = 1'b1; break; end
            tick();
        end
        i_cmd_valid = 1'b0;
        chk($sformatf("push_%0h", id), 32'(ok), 32'd1);
    endtask

    task automatic results(input int n);
        repeat (n) begin
            i_result_valid = 1'b1;
            tick();
        end
        i_result_valid = 1'b0;
    endtask

    task automatic done_pulse();
        i_tile_done = 1'b1;
        tick();
        i_tile_done = 1'b0;
    endtask

    task automatic wait_en();
        bit seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (o_tile_en) begin seen = 1'b1; break; end
            tick();
        end
        chk("tile_en_seen", 32'(seen), 32'd1);
    endtask

    // CE model: pre results, done pulse, gap idle cycles, then post late results.
    task automatic ce_run(input int pre, input int gap, input int post);
        wait_en();
        tick();
        results(pre);
        done_pulse();
        idle(gap);
        results(post);
    endtask

    task automatic check_sts(input int hold, input bit ack);
        sts_t e;
        bit seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (o_sts_valid) begin seen = 1'b1; break; end
            tick();
        end
        chk("sts_seen", 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < hold; k++) begin
            chk("sts_hold_valid", 32'(o_sts_valid), 32'd1);
            chk("sts_hold_id", 32'(o_sts_id), 32'(e.id));
            chk("sts_hold_count", 32'(o_sts_count), 32'(e.cnt));
            tick();
        end
        chk($sformatf("sts_id_%0h", e.id), 32'(o_sts_id), 32'(e.id));
        chk($sformatf("sts_code_%0h", e.id), 32'(o_sts_code), 32'(e.code));
        chk($sformatf("sts_count_%0h", e.id), 32'(o_sts_count), 32'(e.cnt));
        if (ack) begin
            i_sts_ready = 1'b1;
            tick();
            i_sts_ready = 1'b0;
            chk("sts_ack_clear", 32'(o_sts_valid), 32'd0);
        end
    endtask

    initial begin
        // reset state
        idle(2);
        chk("rst_ready", 32'(o_cmd_ready), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_sts_valid", 32'(o_sts_valid), 32'd0);
        chk("rst_tile_en", 32'(o_tile_en), 32'd0);
        i_reset = 1'b0;
        tick();
        chk("rst_ready_after", 32'(o_cmd_ready), 32'd1);

        // single tile, issue latency and held parameters
        e0 = en_cnt;
        sb_push(8'h11, 2'd0, 16'd6);
        push_cmd(8'h11, 11'h123, 11'h456, 8'd2, 8'd3, 8'd4);
        chk("lat_no_en_yet", 32'(o_tile_en), 32'd0);
        chk("lat_busy", 32'(o_busy), 32'd1);
        tick();
        chk("lat_en", 32'(o_tile_en), 32'd1);
        chk("lat_state_issue", 32'(o_state), 32'd1);
        chk("held_left", 32'(o_left_addr), 32'h123);
        chk("held_right", 32'(o_right_addr), 32'h456);
        chk("held_b", 32'(o_dim_b), 32'd2);
        chk("held_c", 32'(o_dim_c), 32'd3);
        chk("held_v", 32'(o_dim_v), 32'd4);
        ce_run(6, 0, 0);
        chk("held_v_drain", 32'(o_dim_v), 32'd4);
        check_sts(0, 1'b1);
        chk("one_en_pulse", 32'(en_cnt - e0), 32'd1);

        // queue full with the status consumer stalled
        sb_push(8'h20, 2'd0, 16'd1);
        push_cmd(8'h20, 11'h10, 11'h20, 8'd1, 8'd1, 8'd1);
        ce_run(1, 0, 0);
        check_sts(0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            sb_push(8'(8'h20 + k), 2'd0, 16'd1);
            push_cmd(8'(8'h20 + k), 11'h10, 11'h20, 8'd1, 8'd1, 8'd1);
        end
        chk("full_ready_low", 32'(o_cmd_ready), 32'd0);
        i_cmd_id = 8'h25; i_cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("full_hold_ready", 32'(o_cmd_ready), 32'd0);
            chk("full_hold_report", 32'(o_state), 32'd4);
            tick();
        end
        i_sts_ready = 1'b1;
        tick();
        i_sts_ready = 1'b0;
        chk("full_idle_ready", 32'(o_cmd_ready), 32'd0);
        tick();
        chk("pop_frees_slot", 32'(o_cmd_ready), 32'd1);
        chk("pop_issue", 32'(o_state), 32'd1);
        tick();
        i_cmd_valid = 1'b0;
        sb_push(8'h25, 2'd0, 16'd1);
        results(1);
        done_pulse();
        check_sts(0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ce_run(1, 0, 0);
            check_sts(0, 1'b1);
        end

        // count mismatch with a late result, then a late result that completes the tile
        sb_push(8'h30, 2'd1, 16'd15);
        push_cmd(8'h30, 11'h7FF, 11'h000, 8'd4, 8'd4, 8'd1);
        ce_run(14, 2, 1);
        check_sts(0, 1'b1);
        sb_push(8'h31, 2'd0, 16'd16);
        push_cmd(8'h31, 11'h001, 11'h002, 8'd4, 8'd4, 8'd1);
        ce_run(15, 1, 1);
        check_sts(0, 1'b1);

        // timeout after 100 RUN cycles, status held while consumer stalls
        i_timeout_cycles = 20'd100;
        sb_push(8'h40, 2'd2, 16'd0);
        push_cmd(8'h40, 11'h0AA, 11'h055, 8'd2, 8'd2, 8'd1);
        wait_en();
        tick();
        i_timeout_cycles = 20'd0;
        idle(99);
        chk("tmo_run_100", 32'(o_state), 32'd2);
        tick();
        chk("tmo_report", 32'(o_state), 32'd4);
        check_sts(10, 1'b1);

        // bad dims: no enable, code 3
        e0 = en_cnt;
        sb_push(8'h50, 2'd3, 16'd0);
        push_cmd(8'h50, 11'h001, 11'h001, 8'd3, 8'd0, 8'd2);
        check_sts(0, 1'b1);
        chk("baddim_no_en", 32'(en_cnt - e0), 32'd0);

        // almost-full gates issue without popping
        i_result_afull = 1'b1;
        sb_push(8'h51, 2'd0, 16'd1);
        push_cmd(8'h51, 11'h002, 11'h003, 8'd1, 8'd1, 8'd1);
        idle(5);
        chk("afull_idle", 32'(o_state), 32'd0);
        chk("afull_busy", 32'(o_busy), 32'd1);
        chk("afull_no_pop", 32'(o_dim_b), 32'd3);
        chk("afull_no_en", 32'(en_cnt - e0), 32'd0);
        i_result_afull = 1'b0;
        tick();
        chk("afull_release_en", 32'(o_tile_en), 32'd1);
        chk("afull_release_b", 32'(o_dim_b), 32'd1);
        ce_run(1, 0, 0);
        check_sts(0, 1'b1);

        // reset mid-RUN aborts the tile and flushes the queue
        push_cmd(8'h60, 11'h100, 11'h200, 8'd2, 8'd2, 8'd2);
        wait_en();
        tick();
        results(2);
        push_cmd(8'h61, 11'h101, 11'h201, 8'd1, 8'd1, 8'd1);
        chk("mid_run", 32'(o_state), 32'd2);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(o_cmd_ready), 32'd0);
        tick();
        chk("rst_mid_state", 32'(o_state), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_sts_valid", 32'(o_sts_valid), 32'd0);
        chk("rst_mid_sts_id", 32'(o_sts_id), 32'd0);
        chk("rst_mid_sts_count", 32'(o_sts_count), 32'd0);
        chk("rst_mid_sts_code", 32'(o_sts_code), 32'd0);
        chk("rst_mid_left", 32'(o_left_addr), 32'd0);
        chk("rst_mid_dim_b", 32'(o_dim_b), 32'd0);
        i_reset = 1'b0;
        tick();
        chk("rst_mid_ready_after", 32'(o_cmd_ready), 32'd1);
        e0 = en_cnt;
        idle(6);
        chk("flush_no_en", 32'(en_cnt - e0), 32'd0);
        chk("flush_no_sts", 32'(o_sts_valid), 32'd0);
        chk("flush_idle", 32'(o_busy), 32'd0);
        sb_push(8'h62, 2'd0, 16'd4);
        push_cmd(8'h62, 11'h300, 11'h301, 8'd2, 8'd2, 8'd1);
        ce_run(4, 0, 0);
        check_sts(0, 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
